// File: rtl/cam_access_ctrl.sv
// Sequencing controller for a 32x32 CAM: one request at a time, per-entry valid bits,
// occupancy tracking and search-then-allocate INSERT. Optional macro: CAM_CTRL_EVICT_EN.
module cam_access_ctrl #(
  parameter int CAM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [4:0]  req_index_i,
  input  logic [31:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_hit_o,
  output logic [4:0]  rsp_index_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        cam_read_enable_o,
  output logic [4:0]  cam_read_index_o,
  output logic        cam_write_enable_o,
  output logic [4:0]  cam_write_index_o,
  output logic [31:0] cam_write_data_o,
  output logic        cam_search_enable_o,
  output logic [31:0] cam_search_data_o,
  input  logic        cam_read_valid_i,
  input  logic [31:0] cam_read_value_i,
  input  logic        cam_search_valid_i,
  input  logic [4:0]  cam_search_index_i,
  output logic [5:0]  occ_count_o,
  output logic        full_o,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a request transfers on a clock edge where req_valid_i && req_ready_o;
  // a response transfers on an edge where rsp_valid_o && rsp_ready_i. Neither side
  // may retract valid before the transfer; ready seen without valid has no effect.

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ALLOC, RESP} state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INSERT = 2'b11;
  localparam logic [1:0] LAT_LAST  = 2'(CAM_LAT - 1);

  state_t      state, state_next;
  logic [1:0]  op_q;
  logic [4:0]  index_q;
  logic [31:0] data_q;
  logic [1:0]  lat_cnt;
  logic [31:0] valid_q;
  logic        rsp_hit_q, rsp_err_q;
  logic [4:0]  rsp_index_q;
  logic [31:0] rsp_data_q;
`ifdef CAM_CTRL_EVICT_EN
  logic [4:0]  victim_q;
`endif

  logic        rd_en, wr_en, se_en;
  logic [4:0]  wr_idx;
  logic [4:0]  free_idx;
  logic        lat_done;
  logic        search_hit;

  assign lat_done   = (lat_cnt == LAT_LAST);
  // The CAM has no valid bits, so a match on a stale entry is a miss.
  assign search_hit = cam_search_valid_i && valid_q[cam_search_index_i];

  always_comb begin
    occ_count_o = '0;
    for (int i = 0; i < 32; i++) occ_count_o = occ_count_o + 6'(valid_q[i]);
  end
  assign full_o = (occ_count_o == 6'd32);

  // Descending scan so the lowest invalid index wins.
  always_comb begin
    free_idx = '0;
    for (int i = 31; i >= 0; i--) if (!valid_q[i]) free_idx = 5'(i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    se_en       = 1'b0;
    wr_idx      = index_q;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = ISSUE;
      end
      ISSUE: begin
        if (op_q == OP_READ) begin
          rd_en      = 1'b1;
          state_next = WAIT;
        end else if (op_q == OP_WRITE) begin
          wr_en      = 1'b1;
          state_next = RESP;
        end else begin
          se_en      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_done) state_next = (op_q == OP_INSERT && !search_hit) ? ALLOC : RESP;
      end
      ALLOC: begin
        state_next = RESP;
        if (!full_o) begin
          wr_en  = 1'b1;
          wr_idx = free_idx;
        end
`ifdef CAM_CTRL_EVICT_EN
        else begin
          wr_en  = 1'b1;
          wr_idx = victim_q;
        end
`endif
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q        <= '0;
      index_q     <= '0;
      data_q      <= '0;
      lat_cnt     <= '0;
      valid_q     <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
`ifdef CAM_CTRL_EVICT_EN
      victim_q    <= '0;
`endif
    end else begin
      if (state == IDLE && req_valid_i) begin
        op_q    <= req_op_i;
        index_q <= req_index_i;
        data_q  <= req_data_i;
      end
      if (state == ISSUE)     lat_cnt <= '0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;
      if (wr_en) valid_q[wr_idx] <= 1'b1;

      if (state == ISSUE && op_q == OP_WRITE) begin
        rsp_hit_q   <= 1'b1;
        rsp_err_q   <= 1'b0;
        rsp_index_q <= index_q;
        rsp_data_q  <= '0;
      end
      if (state == WAIT && lat_done) begin
        rsp_err_q <= 1'b0;
        if (op_q == OP_READ) begin
          rsp_hit_q   <= valid_q[index_q];
          rsp_index_q <= index_q;
          rsp_data_q  <= (valid_q[index_q] && cam_read_valid_i) ? cam_read_value_i : '0;
        end else begin
          rsp_hit_q   <= search_hit;
          rsp_index_q <= search_hit ? cam_search_index_i : 5'd0;
          rsp_data_q  <= '0;
        end
      end
      if (state == ALLOC) begin
        if (!full_o) begin
          rsp_hit_q   <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_index_q <= free_idx;
        end else begin
`ifdef CAM_CTRL_EVICT_EN
          rsp_hit_q   <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_index_q <= victim_q;
          victim_q    <= victim_q + 5'd1;
`else
          rsp_hit_q   <= 1'b0;
          rsp_err_q   <= 1'b1;
          rsp_index_q <= '0;
`endif
        end
      end
    end
  end

  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_index_o = rsp_index_q;
  assign rsp_data_o  = rsp_data_q;

  // Address/data buses are zero whenever their strobe is low.
  assign cam_read_enable_o   = rd_en;
  assign cam_read_index_o    = rd_en ? index_q : 5'd0;
  assign cam_write_enable_o  = wr_en;
  assign cam_write_index_o   = wr_en ? wr_idx : 5'd0;
  assign cam_write_data_o    = wr_en ? data_q : 32'd0;
  assign cam_search_enable_o = se_en;
  assign cam_search_data_o   = se_en ? data_q : 32'd0;

  assign dbg_state_o = state;

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Bench for cam_access_ctrl: behavioural CAM, directed vector table, multi-cycle
// corner sequences and randomized requests checked against a reference model.
`timescale 1ns/1ps
module tb_cam_access_ctrl;
  localparam int CAM_LAT = 1;
  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_SEARCH = 2'd2, OP_INSERT = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_index = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_hit, rsp_err;
  logic [4:0]  rsp_index;
  logic [31:0] rsp_data;
  logic        cam_re, cam_we, cam_se;
  logic [4:0]  cam_ridx, cam_widx;
  logic [31:0] cam_wdata, cam_sdata;
  logic        cam_rvalid, cam_svalid;
  logic [31:0] cam_rvalue;
  logic [4:0]  cam_sidx;
  logic [5:0]  occ_count;
  logic        full;
  logic [2:0]  dbg_state;

  cam_access_ctrl #(.CAM_LAT(CAM_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_index_i(req_index), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit),
    .rsp_index_o(rsp_index), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .cam_read_enable_o(cam_re), .cam_read_index_o(cam_ridx),
    .cam_write_enable_o(cam_we), .cam_write_index_o(cam_widx), .cam_write_data_o(cam_wdata),
    .cam_search_enable_o(cam_se), .cam_search_data_o(cam_sdata),
    .cam_read_valid_i(cam_rvalid), .cam_read_value_i(cam_rvalue),
    .cam_search_valid_i(cam_svalid), .cam_search_index_i(cam_sidx),
    .occ_count_o(occ_count), .full_o(full), .dbg_state_o(dbg_state)
  );

  // ---------------- behavioural CAM (no valid bits, lowest match wins) ----------------
  logic [31:0] cam_mem [32] = '{default: 32'd0};
  logic        rv_p [4] = '{default: 1'b0};
  logic [31:0] rd_p [4] = '{default: 32'd0};
  logic        sv_p [4] = '{default: 1'b0};
  logic [4:0]  si_p [4] = '{default: 5'd0};
  logic        cam_found;
  logic [4:0]  cam_fidx;

  always_comb begin
    cam_found = 1'b0;
    cam_fidx  = 5'd0;
    for (int j = 31; j >= 0; j--)
      if (cam_mem[j] == cam_sdata) begin cam_found = 1'b1; cam_fidx = 5'(j); end
  end

  always @(posedge clk) begin
    for (int k = 3; k > 0; k--) begin
      rv_p[k] <= rv_p[k-1]; rd_p[k] <= rd_p[k-1];
      sv_p[k] <= sv_p[k-1]; si_p[k] <= si_p[k-1];
    end
    rv_p[0] <= cam_re;
    rd_p[0] <= cam_mem[cam_ridx];
    sv_p[0] <= cam_se && cam_found;
    si_p[0] <= cam_fidx;
    if (cam_we) cam_mem[cam_widx] <= cam_wdata;
  end

  assign cam_rvalid = rv_p[CAM_LAT-1];
  assign cam_rvalue = rd_p[CAM_LAT-1];
  assign cam_svalid = sv_p[CAM_LAT-1];
  assign cam_sidx   = si_p[CAM_LAT-1];

  // ---------------- strobe monitor ----------------
  int          wr_pulses = 0;
  int          strobe_viol = 0;
  logic [4:0]  last_wr_idx = '0;
  logic [31:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (cam_we) begin
      wr_pulses++;
      last_wr_idx  = cam_widx;
      last_wr_data = cam_wdata;
    end
    if (int'(cam_re) + int'(cam_we) + int'(cam_se) > 1) strobe_viol++;
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  typedef struct {
    logic        hit;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
    int          occ;
    int          writes;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [31:0] data;
    exp_t        e;
  } vec_t;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [32] = '{default: 32'd0};
  bit          ref_valid [32] = '{default: 1'b0};
  int          ref_vp = 0;

  function automatic int ref_count();
    int c = 0;
    for (int j = 0; j < 32; j++) c += int'(ref_valid[j]);
    return c;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 32; j++) ref_valid[j] = 1'b0;
    ref_vp = 0;
  endtask

  task automatic model_place(input int f, input logic [31:0] d, inout exp_t e);
    ref_mem[f]   = d;
    ref_valid[f] = 1'b1;
    e.hit = 1'b1; e.idx = 5'(f); e.writes = 1; e.wr_idx = 5'(f); e.wr_data = d;
  endtask

  task automatic model_exec(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d,
                            output exp_t e);
    int m = -1;
    int f = -1;
    e = '{hit: 1'b0, idx: 5'd0, data: 32'd0, err: 1'b0, occ: 0, writes: 0,
          wr_idx: 5'd0, wr_data: 32'd0, lat: 2 + CAM_LAT};
    for (int j = 0; j < 32; j++) if (m < 0 && ref_mem[j] == d) m = j;
    case (op)
      OP_READ: begin
        e.hit = ref_valid[idx]; e.idx = idx;
        e.data = ref_valid[idx] ? ref_mem[idx] : 32'd0;
      end
      OP_WRITE: begin
        model_place(int'(idx), d, e);
        e.lat = 2;
      end
      OP_SEARCH: if (m >= 0 && ref_valid[m]) begin e.hit = 1'b1; e.idx = 5'(m); end
      default: begin
        if (m >= 0 && ref_valid[m]) begin
          e.hit = 1'b1; e.idx = 5'(m);
        end else begin
          e.lat = 3 + CAM_LAT;
          for (int j = 31; j >= 0; j--) if (!ref_valid[j]) f = j;
          if (f >= 0) model_place(f, d, e);
          else begin
`ifdef CAM_CTRL_EVICT_EN
            model_place(ref_vp, d, e);
            ref_vp = (ref_vp + 1) % 32;
`else
            e.err = 1'b1;
`endif
          end
        end
      end
    endcase
    e.occ = ref_count();
  endtask

  // ---------------- driver ----------------
  // Starts and ends on a negedge; "lat" counts cycles after the accept edge (ISSUE = 1).
  task automatic run_req(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d,
                         input int hold, input bit early, input exp_t e, input string tag);
    int k = 0;
    int w0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_index = idx; req_data = d; rsp_ready = early;
    @(posedge clk);
    w0 = wr_pulses;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    if (!rsp_valid) begin
      check({tag, ".rsp_timeout"}, 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b0;
      return;
    end
    check({tag, ".lat"}, k, e.lat);
    check({tag, ".hit"}, 32'(rsp_hit), 32'(e.hit));
    check({tag, ".idx"}, 32'(rsp_index), 32'(e.idx));
    check({tag, ".data"}, rsp_data, e.data);
    check({tag, ".err"}, 32'(rsp_err), 32'(e.err));
    check({tag, ".writes"}, wr_pulses - w0, e.writes);
    if (e.writes > 0) begin
      check({tag, ".wr_idx"}, 32'(last_wr_idx), 32'(e.wr_idx));
      check({tag, ".wr_data"}, last_wr_data, e.wr_data);
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check($sformatf("%s.hold%0d.valid", tag, h), 32'(rsp_valid), 32'd1);
        check($sformatf("%s.hold%0d.ready", tag, h), 32'(req_ready), 32'd0);
        check($sformatf("%s.hold%0d.idx", tag, h), 32'(rsp_index), 32'(e.idx));
        check($sformatf("%s.hold%0d.data", tag, h), rsp_data, e.data);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".b2b_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".occ"}, 32'(occ_count), 32'(e.occ));
    check({tag, ".full"}, 32'(full), 32'(e.occ == 32));
  endtask

  task automatic model_run(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d,
                           input int hold, input bit early, input string tag);
    exp_t e;
    model_exec(op, idx, d, e);
    run_req(op, idx, d, hold, early, e, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_hit"}, 32'(rsp_hit), 32'd0);
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, ".rsp_index"}, 32'(rsp_index), 32'd0);
    check({tag, ".rsp_data"}, rsp_data, 32'd0);
    check({tag, ".occ"}, 32'(occ_count), 32'd0);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".cam_en"}, {29'd0, cam_re, cam_we, cam_se}, 32'd0);
    check({tag, ".cam_idx"}, {22'd0, cam_ridx, cam_widx}, 32'd0);
    check({tag, ".cam_wdata"}, cam_wdata, 32'd0);
    check({tag, ".cam_sdata"}, cam_sdata, 32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(tag);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- test ----------------
  vec_t vecs [7];

  initial begin
    vecs[0] = '{OP_READ,   5'd3, 32'h0,        '{1'b0, 5'd3, 32'h0,        1'b0, 0, 0, 5'd0, 32'h0,    2 + CAM_LAT}};
    vecs[1] = '{OP_WRITE,  5'd5, 32'hDEADBEEF, '{1'b1, 5'd5, 32'h0,        1'b0, 1, 1, 5'd5, 32'hDEADBEEF, 2}};
    vecs[2] = '{OP_READ,   5'd5, 32'h0,        '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1, 0, 5'd0, 32'h0,    2 + CAM_LAT}};
    vecs[3] = '{OP_SEARCH, 5'd0, 32'h0,        '{1'b0, 5'd0, 32'h0,        1'b0, 1, 0, 5'd0, 32'h0,    2 + CAM_LAT}};
    vecs[4] = '{OP_SEARCH, 5'd0, 32'hDEADBEEF, '{1'b1, 5'd5, 32'h0,        1'b0, 1, 0, 5'd0, 32'h0,    2 + CAM_LAT}};
    vecs[5] = '{OP_INSERT, 5'd0, 32'h1234,     '{1'b1, 5'd0, 32'h0,        1'b0, 2, 1, 5'd0, 32'h1234, 3 + CAM_LAT}};
    vecs[6] = '{OP_INSERT, 5'd0, 32'h1234,     '{1'b1, 5'd0, 32'h0,        1'b0, 2, 0, 5'd0, 32'h0,    2 + CAM_LAT}};

    @(negedge clk);
    do_reset("reset");

    // Directed table; the model is stepped alongside so later phases stay in sync.
    for (int v = 0; v < 7; v++) begin
      exp_t dummy;
      model_exec(vecs[v].op, vecs[v].idx, vecs[v].data, dummy);
      run_req(vecs[v].op, vecs[v].idx, vecs[v].data, 0, 1'b0, vecs[v].e, $sformatf("vec%0d", v));
    end

    // Response held off for 5 cycles.
    model_run(OP_READ, 5'd5, 32'h0, 5, 1'b0, "hold");

    // Reset asserted while the controller waits on the CAM.
    req_valid = 1'b1; req_op = OP_READ; req_index = 5'd5; req_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midrst.quiet%0d", c), {29'd0, rsp_valid, cam_re, cam_se}, 32'd0);
      check($sformatf("midrst.ready%0d", c), 32'(req_ready), 32'd1);
    end

    // Fill every entry, then INSERT a new key into the full table.
    for (int i = 0; i < 32; i++)
      model_run(OP_WRITE, 5'(i), 32'h1000 + 32'(i), 0, 1'b0, $sformatf("fill%0d", i));
    model_run(OP_INSERT, 5'd0, 32'hCAFE, 0, 1'b0, "full_insert");
`ifdef CAM_CTRL_EVICT_EN
    model_run(OP_INSERT, 5'd0, 32'hCAFF, 0, 1'b0, "full_insert2");
`endif

    // Randomized traffic from a small key pool so searches and inserts collide.
    do_reset("reset2");
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  op;
      logic [4:0]  idx;
      logic [31:0] d;
      op  = 2'($urandom_range(0, 3));
      idx = 5'($urandom_range(0, 31));
      d   = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'h100 + 32'($urandom_range(0, 5));
      model_run(op, idx, d, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                $sformatf("rnd%0d", n));
    end

    check("strobe_exclusive", strobe_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
